// File: rtl/selector_pkg.sv
// Shared types and width helpers for answer_group_selector and its button conditioners.
package selector_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HELD_DELAY,
        REPEATING
    } cond_state_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// Synchronise, debounce and rising-edge detect one raw push-button.
// With AUTOREPEAT_EN defined, a held button also emits periodic repeat pulses.
module button_conditioner
    import selector_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_PERIOD   = 100,
    parameter bit REPEAT_ALLOW    = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic PB,
    output logic PB_pulse
);
    localparam int CW = width_of(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          stable_reg;
    logic          pulse_reg;
    logic [CW-1:0] cnt_reg;
    logic          accept;
    logic          rise;
    logic          repeat_fire;

    // The level is accepted on the edge where the mismatch has persisted DEBOUNCE_CYCLES times.
    assign accept = (sync2_reg != stable_reg) && (cnt_reg == CNT_LAST);
    assign rise   = accept && sync2_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg  <= 1'b0;
            sync2_reg  <= 1'b0;
            stable_reg <= 1'b0;
            cnt_reg    <= '0;
            pulse_reg  <= 1'b0;
        end else begin
            sync1_reg <= PB;
            sync2_reg <= sync1_reg;
            if ((sync2_reg == stable_reg) || accept) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            if (accept) begin
                stable_reg <= sync2_reg;
            end
            pulse_reg <= rise || repeat_fire;
        end
    end

`ifdef AUTOREPEAT_EN
    localparam int RW = width_of(max_of(REPEAT_DELAY, REPEAT_PERIOD));

    cond_state_t   state_reg;
    cond_state_t   state_next;
    logic [RW-1:0] rep_cnt_reg;
    logic [RW-1:0] rep_cnt_next;
    logic          fall;

    assign fall = accept && !sync2_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            rep_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            rep_cnt_reg <= rep_cnt_next;
        end
    end

    // A release wins over a repeat that would land on the same edge.
    always_comb begin
        state_next   = state_reg;
        rep_cnt_next = rep_cnt_reg + 1'b1;
        repeat_fire  = 1'b0;
        if (!REPEAT_ALLOW || fall) begin
            state_next   = IDLE;
            rep_cnt_next = '0;
        end else if (rise) begin
            state_next   = HELD_DELAY;
            rep_cnt_next = '0;
        end else begin
            case (state_reg)
                IDLE: rep_cnt_next = '0;
                HELD_DELAY: begin
                    if (rep_cnt_reg == RW'(REPEAT_DELAY - 1)) begin
                        repeat_fire  = 1'b1;
                        state_next   = REPEATING;
                        rep_cnt_next = '0;
                    end
                end
                REPEATING: begin
                    if (rep_cnt_reg == RW'(REPEAT_PERIOD - 1)) begin
                        repeat_fire  = 1'b1;
                        rep_cnt_next = '0;
                    end
                end
                default: begin
                    state_next   = IDLE;
                    rep_cnt_next = '0;
                end
            endcase
        end
    end
`else
    // Repeat timing has no effect without auto-repeat; folded in so the parameters stay referenced.
    localparam bit REPEAT_CFG = REPEAT_ALLOW && (REPEAT_DELAY > 0) && (REPEAT_PERIOD > 0);
    assign repeat_fire = REPEAT_CFG && 1'b0;
`endif

    assign PB_pulse = pulse_reg;

endmodule

// File: rtl/answer_group_selector.sv
// (page, group) cursor for the seven-segment display mux, stepped by conditioned buttons.
// Define AUTOREPEAT_EN to make held up/down buttons repeat.
module answer_group_selector
    import selector_pkg::*;
#(
    parameter int NUM_GROUPS      = 4,
    parameter int NUM_PAGES       = 2,
    parameter int WRAP            = 1,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_PERIOD   = 100
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
    input  logic                                                 up_button,
    input  logic                                                 down_button,
    input  logic                                                 center_button,
    output logic [width_of(NUM_GROUPS)-1:0]                      out_group,
    output logic [width_of(NUM_PAGES)-1:0]                       out_page,
    output logic [width_of(NUM_PAGES)+width_of(NUM_GROUPS)-1:0]  out_answer_select_code,
    output logic                                                 out_changed
);
    localparam int GW = width_of(NUM_GROUPS);
    localparam int PW = width_of(NUM_PAGES);
    localparam logic [GW-1:0] GROUP_LAST = GW'(NUM_GROUPS - 1);
    localparam logic [PW-1:0] PAGE_LAST  = PW'(NUM_PAGES - 1);
    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_CENTER = 2;

    logic [2:0]    raw_buttons;
    logic [2:0]    press;
    logic [GW-1:0] group_reg;
    logic [GW-1:0] group_next;
    logic [PW-1:0] page_reg;
    logic [PW-1:0] page_next;
    logic          changed_reg;
    logic          changed_next;

    assign raw_buttons = {center_button, down_button, up_button};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_cond
            button_conditioner #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .REPEAT_DELAY   (REPEAT_DELAY),
                .REPEAT_PERIOD  (REPEAT_PERIOD),
                .REPEAT_ALLOW   (gi != BTN_CENTER)
            ) u_cond (
                .clk     (clk),
                .reset   (reset),
                .PB      (raw_buttons[gi]),
                .PB_pulse(press[gi])
            );
        end
    endgenerate

    // Center overrides up/down; opposing up and down pulses cancel.
    always_comb begin
        group_next = group_reg;
        page_next  = page_reg;
        if (press[BTN_CENTER]) begin
            group_next = '0;
            page_next  = (page_reg == PAGE_LAST) ? '0 : page_reg + 1'b1;
        end else if (press[BTN_UP] && !press[BTN_DOWN]) begin
            if (group_reg != GROUP_LAST) begin
                group_next = group_reg + 1'b1;
            end else if (WRAP != 0) begin
                group_next = '0;
            end
        end else if (press[BTN_DOWN] && !press[BTN_UP]) begin
            if (group_reg != '0) begin
                group_next = group_reg - 1'b1;
            end else if (WRAP != 0) begin
                group_next = GROUP_LAST;
            end
        end
        changed_next = (group_next != group_reg) || (page_next != page_reg);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            group_reg   <= '0;
            page_reg    <= '0;
            changed_reg <= 1'b0;
        end else begin
            group_reg   <= group_next;
            page_reg    <= page_next;
            changed_reg <= changed_next;
        end
    end

    assign out_group              = group_reg;
    assign out_page               = page_reg;
    assign out_answer_select_code = {page_reg, group_reg};
    assign out_changed            = changed_reg;

endmodule

// File: tb/tb_answer_group_selector.sv
// Self-checking bench: a wrapping and a saturating selector share stimulus and are
// compared every cycle against a window-based behavioural model.
module tb_answer_group_selector;
    localparam int NG = 5;
    localparam int NP = 3;
    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;
`ifdef AUTOREPEAT_EN
    localparam bit REPEATS = 1'b1;
`else
    localparam bit REPEATS = 1'b0;
`endif

    logic       clk      = 1'b0;
    logic       reset    = 1'b1;
    logic       up_b     = 1'b0;
    logic       down_b   = 1'b0;
    logic       center_b = 1'b0;
    logic [2:0] w_group, s_group;
    logic [1:0] w_page, s_page;
    logic [4:0] w_code, s_code;
    logic       w_changed, s_changed;

    int checks   = 0;
    int failures = 0;

    // Model state: last D+1 raw samples per button, accepted levels, pending pulses, cursors.
    int hist [3][D+1];
    int stable_m [3];
    int held_m [3];
    int pend [3];
    int m_group [2];
    int m_page;
    int m_changed [2];

    always #5 clk = ~clk;

    answer_group_selector #(
        .NUM_GROUPS(NG), .NUM_PAGES(NP), .WRAP(1), .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_w (
        .clk(clk), .reset(reset), .up_button(up_b), .down_button(down_b),
        .center_button(center_b), .out_group(w_group), .out_page(w_page),
        .out_answer_select_code(w_code), .out_changed(w_changed)
    );

    answer_group_selector #(
        .NUM_GROUPS(NG), .NUM_PAGES(NP), .WRAP(0), .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut_s (
        .clk(clk), .reset(reset), .up_button(up_b), .down_button(down_b),
        .center_button(center_b), .out_group(s_group), .out_page(s_page),
        .out_answer_select_code(s_code), .out_changed(s_changed)
    );

    task automatic model_clear();
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i <= D; i++) hist[b][i] = 0;
            stable_m[b] = 0;
            held_m[b]   = 0;
            pend[b]     = 0;
        end
        m_group[0] = 0; m_group[1] = 0;
        m_changed[0] = 0; m_changed[1] = 0;
        m_page = 0;
    endtask

    // Cursor rules: k=0 wraps, k=1 saturates.
    task automatic model_apply();
        int ng [2];
        int np;
        np = m_page;
        for (int k = 0; k < 2; k++) begin
            ng[k] = m_group[k];
            if (pend[2] != 0) ng[k] = 0;
            else if (pend[0] != 0 && pend[1] == 0)
                ng[k] = (k == 0) ? (m_group[k] + 1) % NG : ((m_group[k] < NG - 1) ? m_group[k] + 1 : m_group[k]);
            else if (pend[1] != 0 && pend[0] == 0)
                ng[k] = (k == 0) ? (m_group[k] + NG - 1) % NG : ((m_group[k] > 0) ? m_group[k] - 1 : 0);
        end
        if (pend[2] != 0) np = (m_page + 1) % NP;
        for (int k = 0; k < 2; k++) begin
            m_changed[k] = ((ng[k] != m_group[k]) || (np != m_page)) ? 1 : 0;
            m_group[k]   = ng[k];
        end
        m_page = np;
    endtask

    // A level is accepted once the D samples taken 2..D+1 edges ago all disagree with it.
    task automatic model_edge();
        int raw [3];
        bit flip;
        raw[0] = int'(up_b); raw[1] = int'(down_b); raw[2] = int'(center_b);
        model_apply();
        for (int b = 0; b < 3; b++) begin
            flip = 1'b1;
            pend[b] = 0;
            for (int i = 1; i <= D; i++) if (hist[b][i] == stable_m[b]) flip = 1'b0;
            if (flip) begin
                stable_m[b] = 1 - stable_m[b];
                pend[b]     = stable_m[b];
                held_m[b]   = 0;
            end else if (REPEATS && b != 2 && stable_m[b] == 1) begin
                held_m[b]++;
                if (held_m[b] == RD || (held_m[b] > RD && (held_m[b] - RD) % RP == 0)) pend[b] = 1;
            end
            for (int i = D; i > 0; i--) hist[b][i] = hist[b][i-1];
            hist[b][0] = raw[b];
        end
    endtask

    initial begin
        model_clear();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_clear();
            else model_edge();
        end
    end

    function automatic logic [21:0] obs_vec();
        return {w_page, w_group, w_code, w_changed, s_page, s_group, s_code, s_changed};
    endfunction

    function automatic logic [21:0] exp_vec();
        logic [1:0] p;
        logic [2:0] gw, gs;
        p  = 2'(m_page);
        gw = 3'(m_group[0]);
        gs = 3'(m_group[1]);
        return {p, gw, p, gw, 1'(m_changed[0]), p, gs, p, gs, 1'(m_changed[1])};
    endfunction

    task automatic drive(input logic u, input logic d, input logic c);
        @(negedge clk);
        up_b = u; down_b = d; center_b = c;
    endtask

    task automatic press_only(input int b);
        for (int c = 0; c < 20; c++) drive(c < 10 && b == 0, c < 10 && b == 1, c < 10 && b == 2);
    endtask

    task automatic goto_cursor(input int g, input int p);
        for (int n = 0; n < 8 && m_page != p; n++) press_only(2);
        for (int n = 0; n < 8 && m_group[0] != g; n++) press_only(0);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        if (obs_vec() !== 22'h0) begin
            failures++;
            $display("FAIL reset_state got=%h want=%h", obs_vec(), 22'h0);
        end
        checks++;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 0);
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL reset_idle c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            checks++;
        end
    endtask

    task automatic test_clean_presses();
        int seq_w [6] = '{1, 2, 3, 4, 0, 1};
        int seq_s [6] = '{1, 2, 3, 4, 4, 4};
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < 20; c++) begin
                drive(c < 10, 0, 0);
                if (obs_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL clean_cycle p=%0d c=%0d got=%h want=%h", p, c, obs_vec(), exp_vec());
                end
                checks++;
                if (w_changed !== (c == 7) || s_changed !== (c == 7 && p < 4)) begin
                    failures++;
                    $display("FAIL clean_latency p=%0d c=%0d got=%b%b want=%b%b", p, c,
                             w_changed, s_changed, c == 7, c == 7 && p < 4);
                end
                checks++;
            end
            if (int'(w_group) != seq_w[p] || int'(s_group) != seq_s[p]) begin
                failures++;
                $display("FAIL clean_seq p=%0d got=%0d/%0d want=%0d/%0d", p, w_group, s_group, seq_w[p], seq_s[p]);
            end
            checks++;
        end
    endtask

    task automatic test_glitch();
        int lvl [6] = '{1, 0, 1, 0, 1, 0};
        int len [6] = '{3, 8, 2, 1, 12, 10};
        int nw = 0;
        int ns = 0;
        for (int s = 0; s < 6; s++) begin
            for (int c = 0; c < len[s]; c++) begin
                drive(lvl[s] != 0, 0, 0);
                if (obs_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL glitch_cycle s=%0d c=%0d got=%h want=%h", s, c, obs_vec(), exp_vec());
                end
                checks++;
                if (w_changed) nw++;
                if (s_changed) ns++;
            end
        end
        if (nw != 1 || ns != 0 || w_group !== 3'd2) begin
            failures++;
            $display("FAIL glitch_steps got=%0d/%0d grp=%0d want=1/0 grp=2", nw, ns, w_group);
        end
        checks++;
    endtask

    task automatic test_center();
        goto_cursor(3, 2);
        for (int c = 0; c < 20; c++) begin
            drive(0, 0, c < 10);
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL center_cycle c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            checks++;
        end
        if (w_code !== 5'b00_000 || s_code !== 5'b00_000) begin
            failures++;
            $display("FAIL center_wrap_page got=%h/%h want=00/00", w_code, s_code);
        end
        checks++;
        for (int c = 0; c < 20; c++) begin
            drive(c < 10, 0, c < 10);
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL center_up_cycle c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            checks++;
        end
        if (w_code !== 5'b01_000 || s_code !== 5'b01_000) begin
            failures++;
            $display("FAIL center_priority got=%h/%h want=08/08", w_code, s_code);
        end
        checks++;
    endtask

    task automatic test_up_down_same();
        int nch = 0;
        goto_cursor(2, m_page);
        for (int c = 0; c < 20; c++) begin
            drive(c < 10, c < 10, 0);
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL updown_cycle c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            checks++;
            if (w_changed || s_changed) nch++;
        end
        if (nch != 0 || w_group !== 3'd2 || s_group !== 3'd2) begin
            failures++;
            $display("FAIL updown_hold got=%0d grp=%0d/%0d want=0 grp=2/2", nch, w_group, s_group);
        end
        checks++;
    endtask

    task automatic test_hold();
        int nw = 0;
        int want = REPEATS ? 6 : 1;
        goto_cursor(0, m_page);
        for (int c = 0; c < 80; c++) begin
            drive(c < 60, 0, 0);
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL hold_up_cycle c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            checks++;
            if (w_changed) nw++;
        end
        if (nw != want) begin
            failures++;
            $display("FAIL hold_up_steps got=%0d want=%0d", nw, want);
        end
        checks++;
        nw = 0;
        for (int c = 0; c < 80; c++) begin
            drive(0, 0, c < 60);
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL hold_center_cycle c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            checks++;
            if (w_changed) nw++;
        end
        if (nw != 1) begin
            failures++;
            $display("FAIL hold_center_steps got=%0d want=1", nw);
        end
        checks++;
    endtask

    task automatic test_random();
        int   run [3];
        logic lvl [3];
        for (int b = 0; b < 3; b++) begin run[b] = 0; lvl[b] = 1'b0; end
        for (int c = 0; c < 420; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (run[b] == 0) begin
                    lvl[b] = (c < 400) && ($urandom_range(0, 99) < 35);
                    run[b] = (c < 400) ? int'($urandom_range(1, 12)) : 20;
                end
                run[b]--;
            end
            drive(lvl[0], lvl[1], lvl[2]);
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random_cycle c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            checks++;
        end
        for (int c = 0; c < 20; c++) drive(0, 0, 0);
    endtask

    task automatic test_reset_mid_debounce();
        int nw = 0;
        goto_cursor(3, m_page);
        for (int c = 0; c < 4; c++) drive(1, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        if (obs_vec() !== 22'h0) begin
            failures++;
            $display("FAIL reset_async got=%h want=%h", obs_vec(), 22'h0);
        end
        checks++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 28; c++) begin
            drive(c < 16, 0, 0);
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL reset_redebounce c=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
            checks++;
            if (w_changed) nw++;
        end
        if (nw != 1 || w_group !== 3'd1 || s_group !== 3'd1) begin
            failures++;
            $display("FAIL reset_fresh_press got=%0d grp=%0d/%0d want=1 grp=1/1", nw, w_group, s_group);
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_clean_presses();
        test_glitch();
        test_center();
        test_up_down_same();
        test_hold();
        test_random();
        test_reset_mid_debounce();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
